exposure_timer: RTL and testbench

//  Timing responder to the exposure-control FSM (FSM_ex_control). Owns the

---
 rtl/exposure_timer_pkg.sv | 27 ++
 rtl/exposure_timer_if.sv | 21 ++
 rtl/exposure_timer_ms_prescaler.sv | 25 ++
 rtl/exposure_timer.sv | 122 ++++++++++++
 tb/tb_exposure_timer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/exposure_timer_pkg.sv
// Shared constants, state encoding and exposure-step helper for the exposure timer.
package exposure_timer_pkg;

    localparam int EXP_MIN  = 2;
    localparam int EXP_MAX  = 30;
    localparam int EXP_INIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXPOSING,
        ST_EXP_DONE,
        ST_READING,
        ST_READ_DONE
    } timer_state_t;

    // Opposing edges in the same cycle cancel; the result saturates at the limits.
    function automatic logic [4:0] step_exp(input logic [4:0] cur, input logic up, input logic dn);
        logic [4:0] nxt;
        nxt = cur;
        if (up && !dn && (cur < 5'(EXP_MAX)))
            nxt = cur + 5'd1;
        else if (dn && !up && (cur > 5'(EXP_MIN)))
            nxt = cur - 5'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/exposure_timer_if.sv
// Control/status bundle between the exposure-control FSM (master) and the exposure timer (slave).
interface exposure_timer_if;
    logic       exp_increase;
    logic       exp_decrease;
    logic       expose;
    logic       adc;
    logic       ovf5;
    logic       ovf4;
    logic       busy;
    logic [4:0] exp_time;

    modport master (
        output exp_increase, exp_decrease, expose, adc,
        input  ovf5, ovf4, busy, exp_time
    );

    modport slave (
        input  exp_increase, exp_decrease, expose, adc,
        output ovf5, ovf4, busy, exp_time
    );
endinterface

// File: rtl/exposure_timer_ms_prescaler.sv
// Divides the system clock down to one tick per millisecond while enabled.
module ms_prescaler #(
    parameter int CLK_PER_MS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = $clog2(CLK_PER_MS);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == W'(CLK_PER_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: owns the ms exposure setting and times the expose and ADC readout phases.
//  state        | meaning
//  ST_IDLE      | waiting for expose or adc; setting changes accepted
//  ST_EXPOSING  | counting down ms_cnt on each prescaler tick
//  ST_EXP_DONE  | ovf5 issued, waiting for expose to drop
//  ST_READING   | counting readout cycles in rd_cnt
//  ST_READ_DONE | ovf4 issued, waiting for adc to drop
module exposure_timer
    import exposure_timer_pkg::*;
#(
    parameter int CLK_PER_MS  = 1000,
    parameter int READ_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    exposure_timer_if.slave bus
);
    localparam int RW = $clog2(READ_CYCLES + 1);

    timer_state_t  state;
    logic [4:0]    ms_cnt;
    logic [RW-1:0] rd_cnt;
    logic [4:0]    exp_time;
    logic          inc_q, dec_q;
    logic          ovf5, ovf4, busy;
    logic          ms_tick;

    assign bus.exp_time = exp_time;
    assign bus.ovf5     = ovf5;
    assign bus.ovf4     = ovf4;
    assign bus.busy     = busy;

    ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != ST_EXPOSING),
        .enable(state == ST_EXPOSING),
        .tick  (ms_tick)
    );

    // Edge history tracks every cycle so edges seen outside IDLE are dropped, not replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_time <= 5'(EXP_INIT);
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            inc_q <= bus.exp_increase;
            dec_q <= bus.exp_decrease;
            if (state == ST_IDLE)
                exp_time <= step_exp(exp_time, bus.exp_increase && !inc_q,
                                     bus.exp_decrease && !dec_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ms_cnt <= '0;
            rd_cnt <= '0;
            ovf5   <= 1'b0;
            ovf4   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ovf5 <= 1'b0;
            ovf4 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.expose) begin
                        state  <= ST_EXPOSING;
                        ms_cnt <= exp_time;
                        busy   <= 1'b1;
                    end else if (bus.adc) begin
                        state  <= ST_READING;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_EXPOSING: begin
                    if (!bus.expose) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt - 5'd1;
                        if (ms_cnt == 5'd1) begin
                            state <= ST_EXP_DONE;
                            ovf5  <= 1'b1;
                        end
                    end
                end
                ST_EXP_DONE: begin
                    if (!bus.expose) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_READING: begin
                    if (!bus.adc) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == RW'(READ_CYCLES - 1)) begin
                            state <= ST_READ_DONE;
                            ovf4  <= 1'b1;
                        end
                    end
                end
                ST_READ_DONE: begin
                    if (!bus.adc) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exposure_timer.sv
// Directed self-checking bench for exposure_timer with CLK_PER_MS=4, READ_CYCLES=4.
module tb_exposure_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    exposure_timer_if bus();

    exposure_timer #(.CLK_PER_MS(4), .READ_CYCLES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic pulse(input logic up, input logic dn);
        @(negedge clk);
        bus.exp_increase = up;
        bus.exp_decrease = dn;
        @(negedge clk);
        bus.exp_increase = 1'b0;
        bus.exp_decrease = 1'b0;
    endtask

    task automatic test_reset();
        bus.exp_increase = 1'b0;
        bus.exp_decrease = 1'b0;
        bus.expose = 1'b0;
        bus.adc = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.exp_time !== 5'd2) begin n_fail++; $display("FAIL reset_exp_time: got %0d want 2", bus.exp_time); end
        n_checks++;
        if (bus.ovf5 !== 1'b0 || bus.ovf4 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got ovf5=%b ovf4=%b want 0 0", bus.ovf5, bus.ovf4); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    // Exposure of 2 ms = 8 cycles: ovf5 after edge k+8 only.
    task automatic test_expose();
        @(negedge clk);
        bus.expose = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL expose_busy_start: got %b want 1", bus.busy); end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf5 !== (i == 8)) begin n_fail++; $display("FAIL expose_ovf5 cycle+%0d: got %b want %b", i, bus.ovf5, (i == 8)); end
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL expose_busy_hold: got %b want 1", bus.busy); end
        @(negedge clk);
        bus.expose = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL expose_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_setting();
        pulse(1'b1, 1'b0);
        n_checks++;
        if (bus.exp_time !== 5'd3) begin n_fail++; $display("FAIL set_inc1: got %0d want 3", bus.exp_time); end
        @(negedge clk);
        bus.exp_increase = 1'b1;
        n_checks++;
        if (bus.exp_time !== 5'd3) begin n_fail++; $display("FAIL set_latency_before: got %0d want 3", bus.exp_time); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.exp_time !== 5'd4) begin n_fail++; $display("FAIL set_latency_after: got %0d want 4", bus.exp_time); end
        @(negedge clk);
        bus.exp_increase = 1'b0;
        repeat (28) pulse(1'b1, 1'b0);
        n_checks++;
        if (bus.exp_time !== 5'd30) begin n_fail++; $display("FAIL set_sat_max: got %0d want 30", bus.exp_time); end
        pulse(1'b0, 1'b1);
        n_checks++;
        if (bus.exp_time !== 5'd29) begin n_fail++; $display("FAIL set_dec1: got %0d want 29", bus.exp_time); end
        repeat (39) pulse(1'b0, 1'b1);
        n_checks++;
        if (bus.exp_time !== 5'd2) begin n_fail++; $display("FAIL set_sat_min: got %0d want 2", bus.exp_time); end
        repeat (3) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        n_checks++;
        if (bus.exp_time !== 5'd5) begin n_fail++; $display("FAIL set_both: got %0d want 5", bus.exp_time); end
        repeat (3) pulse(1'b0, 1'b1);
        n_checks++;
        if (bus.exp_time !== 5'd2) begin n_fail++; $display("FAIL set_restore: got %0d want 2", bus.exp_time); end
    endtask

    task automatic test_adc();
        @(negedge clk);
        bus.adc = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf4 !== (i == 4)) begin n_fail++; $display("FAIL adc_ovf4 cycle+%0d: got %b want %b", i, bus.ovf4, (i == 4)); end
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL adc_busy_done: got %b want 1", bus.busy); end
        @(negedge clk);
        bus.adc = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL adc_busy_end: got %b want 0", bus.busy); end
        // Abort: adc sampled low at edge k+3, one edge before expiry.
        @(negedge clk);
        bus.adc = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) begin
                @(negedge clk);
                bus.adc = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf4 !== 1'b0) begin n_fail++; $display("FAIL adc_abort_ovf4 cycle+%0d: got %b want 0", i, bus.ovf4); end
            if (i == 3) begin
                n_checks++;
                if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL adc_abort_idle: got busy=%b want 0", bus.busy); end
            end
        end
    endtask

    task automatic test_locked_setting();
        @(negedge clk);
        bus.expose = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                @(negedge clk);
                bus.exp_increase = 1'b1;
            end
            if (i == 4) begin
                @(negedge clk);
                bus.exp_increase = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf5 !== (i == 8)) begin n_fail++; $display("FAIL locked_ovf5 cycle+%0d: got %b want %b", i, bus.ovf5, (i == 8)); end
        end
        n_checks++;
        if (bus.exp_time !== 5'd2) begin n_fail++; $display("FAIL locked_exp_time: got %0d want 2", bus.exp_time); end
        @(negedge clk);
        bus.expose = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.exp_time !== 5'd2) begin n_fail++; $display("FAIL locked_no_queue: got %0d want 2", bus.exp_time); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.expose = 1'b1;
        bus.adc = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf5 !== (i == 8) || bus.ovf4 !== 1'b0) begin
                n_fail++;
                $display("FAIL priority cycle+%0d: got ovf5=%b ovf4=%b want %b 0", i, bus.ovf5, bus.ovf4, (i == 8));
            end
        end
        @(negedge clk);
        bus.expose = 1'b0;
        bus.adc = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        pulse(1'b1, 1'b0);
        @(negedge clk);
        bus.expose = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf5 !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_ovf5 cycle+%0d: got %b want 0", i, bus.ovf5); end
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.exp_time !== 5'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre_state: got busy=%b exp_time=%0d want 1 3", bus.busy, bus.exp_time);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ovf5 !== 1'b0 || bus.ovf4 !== 1'b0 || bus.exp_time !== 5'd2) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b ovf5=%b ovf4=%b exp_time=%0d want 0 0 0 2",
                     bus.busy, bus.ovf5, bus.ovf4, bus.exp_time);
        end
        @(negedge clk);
        bus.expose = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.ovf5 !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_post cycle+%0d: got ovf5=%b busy=%b want 0 0", i, bus.ovf5, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_expose();
        test_setting();
        test_adc();
        test_locked_setting();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
